// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of one PicoRV32-style native memory port.
// Optional busy watchdog enabled by the ARB_TIMEOUT_EN macro.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    s0_valid,
    input  logic                    s0_instr,
    input  logic [ADDR_WIDTH-1:0]   s0_addr,
    input  logic [DATA_WIDTH-1:0]   s0_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
    output logic                    s0_ready,
    output logic [DATA_WIDTH-1:0]   s0_rdata,
    input  logic                    s1_valid,
    input  logic                    s1_instr,
    input  logic [ADDR_WIDTH-1:0]   s1_addr,
    input  logic [DATA_WIDTH-1:0]   s1_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
    output logic                    s1_ready,
    output logic [DATA_WIDTH-1:0]   s1_rdata,
    output logic                    m_valid,
    output logic                    m_instr,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    input  logic                    m_ready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    output logic [1:0]              gnt,
    output logic                    timeout_err
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY    = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    state_t                  state_r, state_s;
    logic                    last_gnt_r, last_gnt_s;
    logic                    win_s;
    logic [1:0]              gnt_s;
    logic                    m_valid_s, m_instr_s;
    logic [ADDR_WIDTH-1:0]   m_addr_s;
    logic [DATA_WIDTH-1:0]   m_wdata_s;
    logic [STRB_WIDTH-1:0]   m_wstrb_s;
    logic                    cpl_s;
    logic [DATA_WIDTH-1:0]   cpl_data_s;
    logic                    s0_ready_s, s1_ready_s;
    logic [DATA_WIDTH-1:0]   s0_rdata_s, s1_rdata_s;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_r, cnt_s;
    logic        timeout_err_s;
`endif

    // Round-robin: on a tie the requester that did not win last time is served.
    function automatic logic pick_winner(input logic v0, input logic v1, input logic last);
        logic w;
        if (v0 && v1) begin
            w = ~last;
        end else begin
            w = v1;
        end
        return w;
    endfunction

    // Next-state and next-output logic of the arbitration FSM.
    always_comb begin
        state_s    = state_r;
        last_gnt_s = last_gnt_r;
        win_s      = 1'b0;
        gnt_s      = gnt;
        m_valid_s  = m_valid;
        m_instr_s  = m_instr;
        m_addr_s   = m_addr;
        m_wdata_s  = m_wdata;
        m_wstrb_s  = m_wstrb;
        cpl_s      = 1'b0;
        cpl_data_s = m_rdata;
`ifdef ARB_TIMEOUT_EN
        cnt_s         = cnt_r;
        timeout_err_s = timeout_err;
`endif
        case (state_r)
            ST_IDLE: begin
                if (s0_valid || s1_valid) begin
                    win_s      = pick_winner(s0_valid, s1_valid, last_gnt_r);
                    last_gnt_s = win_s;
                    gnt_s      = win_s ? 2'b10 : 2'b01;
                    m_valid_s  = 1'b1;
                    if (win_s) begin
                        m_instr_s = s1_instr;
                        m_addr_s  = s1_addr;
                        m_wdata_s = s1_wdata;
                        m_wstrb_s = s1_wstrb;
                    end else begin
                        m_instr_s = s0_instr;
                        m_addr_s  = s0_addr;
                        m_wdata_s = s0_wdata;
                        m_wstrb_s = s0_wstrb;
                    end
`ifdef ARB_TIMEOUT_EN
                    cnt_s = 16'd0;
`endif
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // A real completion takes priority over a watchdog expiry in the same cycle.
                if (m_ready) begin
                    cpl_s      = 1'b1;
                    cpl_data_s = m_rdata;
                    m_valid_s  = 1'b0;
                    state_s    = ST_RELEASE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_r == TIMEOUT_LAST) begin
                    cpl_s         = 1'b1;
                    cpl_data_s    = DATA_WIDTH'(32'hDEADBEEF);
                    m_valid_s     = 1'b0;
                    timeout_err_s = 1'b1;
                    state_s       = ST_RELEASE;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
`else
                else begin
                    state_s = ST_BUSY;
                end
`endif
            end
            ST_RELEASE: begin
                // Extra idle cycle keeps m_valid low long enough for the bridge to go idle.
                gnt_s   = 2'b00;
                state_s = ST_IDLE;
            end
            default: begin
                gnt_s     = 2'b00;
                m_valid_s = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // Route a completion back to the current owner only.
    always_comb begin
        s0_ready_s = 1'b0;
        s1_ready_s = 1'b0;
        s0_rdata_s = s0_rdata;
        s1_rdata_s = s1_rdata;
        if (cpl_s && gnt[0]) begin
            s0_ready_s = 1'b1;
            s0_rdata_s = cpl_data_s;
        end else if (cpl_s && gnt[1]) begin
            s1_ready_s = 1'b1;
            s1_rdata_s = cpl_data_s;
        end else begin
            s0_ready_s = 1'b0;
            s1_ready_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r    <= ST_IDLE;
            last_gnt_r <= 1'b1;
            gnt        <= 2'b00;
            m_valid    <= 1'b0;
            m_instr    <= 1'b0;
            m_addr     <= {ADDR_WIDTH{1'b0}};
            m_wdata    <= {DATA_WIDTH{1'b0}};
            m_wstrb    <= {STRB_WIDTH{1'b0}};
            s0_ready   <= 1'b0;
            s1_ready   <= 1'b0;
            s0_rdata   <= {DATA_WIDTH{1'b0}};
            s1_rdata   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r    <= state_s;
            last_gnt_r <= last_gnt_s;
            gnt        <= gnt_s;
            m_valid    <= m_valid_s;
            m_instr    <= m_instr_s;
            m_addr     <= m_addr_s;
            m_wdata    <= m_wdata_s;
            m_wstrb    <= m_wstrb_s;
            s0_ready   <= s0_ready_s;
            s1_ready   <= s1_ready_s;
            s0_rdata   <= s0_rdata_s;
            s1_rdata   <= s1_rdata_s;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_r       <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            cnt_r       <= cnt_s;
            timeout_err <= timeout_err_s;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter sharing one PicoRV32-style native memory port, which is typically the front end of the SoC's AXI4 master bridge.
- Requester 0 is normally the CPU; requester 1 is a DMA or debug engine.
- Round-robin arbitration; one transaction in flight at a time.
- Request fields are registered at grant. Each completion is returned to the winner as a single-cycle ready pulse.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports (strobe width DATA_WIDTH/8)
TIMEOUT_CYCLES, 1024, watchdog limit (used only with ARB_TIMEOUT_EN)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s0_valid  in  1  requester 0 request
s0_instr  in  1  requester 0 instruction-fetch flag
s0_addr  in  ADDR_WIDTH  requester 0 address
s0_wdata  in  DATA_WIDTH  requester 0 write data
s0_wstrb  in  DATA_WIDTH/8  requester 0 byte strobes (0 = read)
s0_ready  out  1  requester 0 completion pulse
s0_rdata  out  DATA_WIDTH  requester 0 read data
s1_valid, s1_instr, s1_addr, s1_wdata, s1_wstrb, s1_ready, s1_rdata  same as s0_*, for requester 1
m_valid  out  1  downstream request
m_instr  out  1  downstream instruction flag
m_addr  out  ADDR_WIDTH  downstream address
m_wdata  out  DATA_WIDTH  downstream write data
m_wstrb  out  DATA_WIDTH/8  downstream strobes
m_ready  in  1  downstream completion pulse
m_rdata  in  DATA_WIDTH  downstream read data
gnt  out  2  one-hot current owner (00 when idle)
timeout_err  out  1  sticky watchdog flag (0 unless ARB_TIMEOUT_EN)

Behaviour:
- Reset (aresetn low, async):
  - All outputs 0; state IDLE; last_gnt = 1, so requester 0 wins the first tie.
  - Reset mid-transaction drops m_valid immediately. No ready pulse is issued.
- States: IDLE, BUSY, RELEASE. Every output is registered.
- IDLE:
  - Only s0_valid: grant 0. Only s1_valid: grant 1.
  - Both valid: grant the requester != last_gnt.
  - On grant: latch that requester's instr/addr/wdata/wstrb into m_*; m_valid<=1; gnt<=one-hot; last_gnt<=winner; go BUSY.
  - Grant-to-m_valid latency is 1 cycle.
- BUSY:
  - m_* held stable while m_valid=1.
  - On m_ready=1: m_valid<=0; winner's sN_rdata<=m_rdata; sN_ready<=1 for exactly 1 cycle; go RELEASE.
  - m_ready-to-sN_ready latency is 1 cycle.
  - m_rdata is captured for writes too; requesters ignore it.
- RELEASE:
  - sN_ready<=0; gnt<=00; go IDLE. Requests are not sampled in this state.
  - Guarantees m_valid is low for at least 2 cycles between transactions, so the downstream bridge sees !m_valid and returns to its idle state.
- Owner behaviour:
  - The non-granted requester's ready stays 0; its valid may stay high indefinitely and is served next.
  - Requesters must drop valid in the cycle after their ready pulse. A request still high in IDLE is treated as a new transaction.
  - sN_valid falling during BUSY (protocol violation) is ignored; the transaction completes normally.
- Back-to-back contention: with both valid continuously, grants alternate 0,1,0,1. Each transaction takes at least 3 cycles plus downstream latency.
- sN_rdata holds its last captured value between pulses.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without m_ready: m_valid<=0; winner's rdata<=32'hDEADBEEF; winner's ready pulses; timeout_err<=1 (sticky until reset); go RELEASE.
  - An m_ready arriving in the same cycle as the timeout wins: normal completion, no error.
- Undefined: no counter; BUSY waits forever; timeout_err tied 0.

Test Plan:
- s0 read of 0x0000_0010, downstream m_ready after 3 cycles with m_rdata=0x1234_5678 -> m_addr=0x10, m_wstrb=0; s0_ready pulses once 1 cycle after m_ready with s0_rdata=0x12345678; s1_ready stays 0.
- s1 write 0x2000_0004, data 0xCAFEF00D, wstrb 4'b0011 -> m_* match the request, gnt=2'b10, s1_ready pulses once, gnt returns to 00 after RELEASE.
- s0 and s1 both valid from the same cycle after reset -> s0 served first, then s1. With both reissued immediately, the order continues s0, s1, s0.
- s1 valid held throughout an s0 transaction -> s1 granted in the first IDLE after RELEASE; m_valid low for exactly 2 cycles between the transactions.
- aresetn asserted while BUSY with m_valid=1 -> m_valid, gnt, s0_ready and s1_ready all 0 at once. After release, a new s1 request is granted cleanly.
- ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, m_ready never asserted -> after 8 BUSY cycles the winner gets a ready pulse with rdata 0xDEADBEEF and timeout_err=1 stays set.
